// File: rtl/dmem_responder_if.sv
// Request/response bundle between the execute stage and the data-memory responder.
// Handshake: the responder is always ready; a request is any cycle with mem_re or a
// nonzero we, and rvalid qualifies rdata/rerr exactly two enabled edges later.
interface dmem_responder_if;
  logic [31:0] addr;
  logic        mem_re;
  logic [3:0]  we;
  logic [31:0] store_data;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rerr;
  logic        werr;

  modport master (
    output addr, mem_re, we, store_data,
    input  rdata, rvalid, rerr, werr
  );

  modport slave (
    input  addr, mem_re, we, store_data,
    output rdata, rvalid, rerr, werr
  );
endinterface

// File: rtl/dmem_responder.sv
// Two-stage data-memory responder: stage A holds the request, the array is written
// and read (old data) at the edge A retires, stage B presents the returned word.
module dmem_responder #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             halt,
  dmem_responder_if.slave  bus
);

  logic [31:0]   r_mem [0:DEPTH-1];

  logic          r_a_valid;
  logic          r_a_re;
  logic [3:0]    r_a_we;
  logic [31:0]   r_a_data;
  logic [AW-1:0] r_a_idx;
  logic          r_a_oor;

  logic          r_b_valid;
  logic [31:0]   r_b_data;
  logic          r_b_err;
  logic          r_werr;

  logic          w_adv;
  logic          w_oor;
  logic          w_req;
  logic          w_unused;

  assign w_adv    = clk_en & ~halt;
  assign w_oor    = (bus.addr[31:2] >= 30'(DEPTH));
  assign w_req    = bus.mem_re | (|bus.we);
  assign w_unused = &{1'b0, bus.addr[1:0]};

  // Control and output state; only these are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_data  <= 32'h0;
      r_b_err   <= 1'b0;
      r_werr    <= 1'b0;
    end else if (clk_en) begin
      if (halt) begin
        r_a_valid <= 1'b0;
        r_b_valid <= 1'b0;
        r_b_err   <= 1'b0;
        r_werr    <= 1'b0;
      end else begin
        r_a_valid <= w_req;
        r_b_valid <= r_a_valid & r_a_re;
        r_b_err   <= r_a_valid & r_a_re & r_a_oor;
        r_werr    <= r_a_valid & r_a_oor & (|r_a_we);
        if (r_a_valid && r_a_re)
          r_b_data <= r_a_oor ? 32'h0 : r_mem[r_a_idx];
      end
    end
  end

  // Stage A payload needs no reset: it is only consumed while r_a_valid is set.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a_re   <= bus.mem_re;
      r_a_we   <= bus.we;
      r_a_data <= bus.store_data;
      r_a_idx  <= bus.addr[AW+1:2];
      r_a_oor  <= w_oor;
    end
  end

  // Commit happens on the same edge B samples the array, so B sees pre-write data.
  always_ff @(posedge clk) begin
    if (w_adv && r_a_valid && !r_a_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (r_a_we[i])
          r_mem[r_a_idx][8*i +: 8] <= r_a_data[8*i +: 8];
      end
    end
  end

  assign bus.rdata  = r_b_data;
  assign bus.rvalid = r_b_valid;
  assign bus.rerr   = r_b_err;
  assign bus.werr   = r_werr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one task per scenario, inline checks,
// single summary line at the end.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  logic clk_en;
  logic halt;
  int   errors;
  int   checks;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(16384), .AW(14)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .halt   (halt),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bubble();
    bus.addr       = 32'h0;
    bus.mem_re     = 1'b0;
    bus.we         = 4'h0;
    bus.store_data = 32'h0;
  endtask

  // Present one request for one edge, return 1ns after that edge.
  task automatic issue(input logic [31:0] a, input logic re, input logic [3:0] w,
                       input logic [31:0] d);
    bus.addr       = a;
    bus.mem_re     = re;
    bus.we         = w;
    bus.store_data = d;
    @(posedge clk);
    #1;
    drive_bubble();
  endtask

  task automatic bubble_edge();
    drive_bubble();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    clk_en = 1'b1;
    halt   = 1'b0;
    drive_bubble();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.rerr !== 1'b0) begin errors++; $display("FAIL reset_rerr got=%b exp=0", bus.rerr); end
    checks++; if (bus.werr !== 1'b0) begin errors++; $display("FAIL reset_werr got=%b exp=0", bus.werr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    issue(32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    issue(32'h10, 1'b1, 4'h0, 32'h0);
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL basic_early_rvalid got=%b exp=0", bus.rvalid); end
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL basic_rvalid got=%b exp=1", bus.rvalid); end
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got=%h exp=deadbeef", bus.rdata); end
    checks++; if (bus.rerr !== 1'b0) begin errors++; $display("FAIL basic_rerr got=%b exp=0", bus.rerr); end
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL basic_rvalid_drop got=%b exp=0", bus.rvalid); end
  endtask

  task automatic test_byte_merge();
    issue(32'h20, 1'b0, 4'hF, 32'h11223344);
    issue(32'h22, 1'b0, 4'b0100, 32'h00AA0000);
    issue(32'h20, 1'b1, 4'h0, 32'h0);
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL merge_rvalid got=%b exp=1", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h11AA3344) begin errors++; $display("FAIL merge_rdata got=%h exp=11aa3344", bus.rdata); end
  endtask

  task automatic test_back_to_back();
    issue(32'h30, 1'b0, 4'hF, 32'h5);
    issue(32'h30, 1'b0, 4'hF, 32'h1);
    issue(32'h30, 1'b1, 4'h0, 32'h0);
    issue(32'h30, 1'b1, 4'hF, 32'h2);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) begin errors++; $display("FAIL b2b_read_after_write got=%b/%h exp=1/00000001", bus.rvalid, bus.rdata); end
    issue(32'h30, 1'b1, 4'h0, 32'h0);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) begin errors++; $display("FAIL b2b_rmw_old got=%b/%h exp=1/00000001", bus.rvalid, bus.rdata); end
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h2) begin errors++; $display("FAIL b2b_later_new got=%b/%h exp=1/00000002", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_out_of_range();
    issue(32'h0, 1'b0, 4'hF, 32'hCAFEF00D);
    issue(32'h00010000, 1'b1, 4'h0, 32'h0);
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL oor_rvalid got=%b exp=1", bus.rvalid); end
    checks++; if (bus.rerr !== 1'b1) begin errors++; $display("FAIL oor_rerr got=%b exp=1", bus.rerr); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", bus.rdata); end
    issue(32'h00010000, 1'b0, 4'hF, 32'h12345678);
    checks++; if (bus.werr !== 1'b0) begin errors++; $display("FAIL oor_werr_early got=%b exp=0", bus.werr); end
    bubble_edge();
    checks++; if (bus.werr !== 1'b1) begin errors++; $display("FAIL oor_werr got=%b exp=1", bus.werr); end
    bubble_edge();
    checks++; if (bus.werr !== 1'b0) begin errors++; $display("FAIL oor_werr_pulse got=%b exp=0", bus.werr); end
    issue(32'h0, 1'b1, 4'h0, 32'h0);
    bubble_edge();
    checks++; if (bus.rdata !== 32'hCAFEF00D || bus.rerr !== 1'b0) begin errors++; $display("FAIL oor_no_alias got=%h/%b exp=cafef00d/0", bus.rdata, bus.rerr); end
  endtask

  task automatic test_clk_en();
    issue(32'h20, 1'b1, 4'h0, 32'h0);
    issue(32'h10, 1'b1, 4'h0, 32'h0);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11AA3344) begin errors++; $display("FAIL clken_pre got=%b/%h exp=1/11aa3344", bus.rvalid, bus.rdata); end
    clk_en         = 1'b0;
    bus.addr       = 32'h10;
    bus.we         = 4'hF;
    bus.store_data = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11AA3344) begin errors++; $display("FAIL clken_frozen%0d got=%b/%h exp=1/11aa3344", i, bus.rvalid, bus.rdata); end
    end
    drive_bubble();
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL clken_resume got=%b/%h exp=1/deadbeef", bus.rvalid, bus.rdata); end
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL clken_after got=%b exp=0", bus.rvalid); end
  endtask

  task automatic test_halt();
    issue(32'h40, 1'b0, 4'hF, 32'h77);
    issue(32'h10, 1'b1, 4'h0, 32'h0);
    issue(32'h40, 1'b0, 4'hF, 32'h99);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL halt_pre got=%b/%h exp=1/deadbeef", bus.rvalid, bus.rdata); end
    halt = 1'b1;
    issue(32'h50, 1'b1, 4'h0, 32'h0);
    halt = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL halt_rvalid got=%b exp=0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL halt_rdata_hold got=%h exp=deadbeef", bus.rdata); end
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL halt_discard got=%b exp=0", bus.rvalid); end
    issue(32'h40, 1'b1, 4'h0, 32'h0);
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h77) begin errors++; $display("FAIL halt_no_commit got=%b/%h exp=1/00000077", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_async_reset();
    issue(32'h40, 1'b1, 4'h0, 32'h0);
    issue(32'h40, 1'b0, 4'hF, 32'hEE);
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", bus.rvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL areset_rvalid got=%b exp=0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL areset_rdata got=%h exp=0", bus.rdata); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h40, 1'b1, 4'h0, 32'h0);
    bubble_edge();
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h77) begin errors++; $display("FAIL areset_persist got=%b/%h exp=1/00000077", bus.rvalid, bus.rdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_byte_merge();
    test_back_to_back();
    test_out_of_range();
    test_clk_en();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the execute stage's memory request interface.
- Accepts one request per cycle: word-address, read-enable, 4-bit byte-lane write enable, and lane-positioned store data. Returns the full 32-bit word two clocks later.
- The return lines up with the mem_a/mem_b stages, so the load result is ready when the instruction reaches mem_b.
- Byte/halfword lane extraction and sign extension for loads are done downstream, not here.

Parameters:
- DEPTH, 16384, number of 32-bit words in the internal array; a power of two.
- AW, 14, word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; when 0, all state holds.
- halt  in  1  flushes in-flight requests; same timing as the pipeline halt.
- addr  in  32  byte address from execute; bits [1:0] are ignored for the array index.
- mem_re  in  1  read request.
- we  in  4  byte-lane write enables; bit i writes store_data[8i+7:8i].
- store_data  in  32  write data, already lane-positioned.
- rdata  out  32  returned word.
- rvalid  out  1  rdata is valid this cycle.
- rerr  out  1  the returned request was out of range.
- werr  out  1  one-cycle pulse when an out-of-range write is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): stage A and stage B valid bits = 0; rdata=0; rvalid=0; rerr=0; werr=0. Array contents are not reset. Deassertion is used synchronously on the next edge.
- Out-of-range: a request is out of range (oor) when addr[31:2] >= DEPTH.
- Edge E0 (clk_en=1, halt=0): capture into stage A.
  - Stored fields: idx=addr[AW+1:2], re=mem_re, we, data=store_data, oor.
  - A_valid = mem_re | (|we).
- Edge E1: stage A retires.
  - Read: if A.re, B captures array[idx] as it was before E1 (read-old-data, even when the same request also writes).
  - Write: array[idx] updates each lane whose we bit is set, only if !oor.
  - Read result: B.valid = A.valid & A.re; B.err = A.oor.
  - If A.oor, B.data = 0.
  - If oor and |we, the write is dropped and werr=1 for one cycle after E1; otherwise werr=0.
- Outputs: rdata=B.data, rvalid=B.valid, rerr=B.err, all registered. Load latency is exactly 2 edges from request to rvalid.
- Throughput: back-to-back requests every cycle.
  - A read at cycle N+1 sees a write issued at cycle N, because the write commits at the edge where the read is still in A.
  - No stall output; always ready.
- clk_en=0: no state changes, including the array; outputs hold.
- halt=1 with clk_en=1:
  - A_valid and B.valid clear; rvalid=0; werr=0.
  - Any write in A is not committed; the incoming request is discarded.
  - rdata holds its last value.
- Lane enables: we=0 with mem_re=0 is a bubble, and A_valid=0. Any we pattern is accepted; no alignment check here.
- Reset mid-operation: in-flight requests are lost and a pending write in A is not committed. Words written at earlier edges persist.

Test Plan:
- Reset, then write addr=0x10, we=4'hF, data=0xDEADBEEF; read addr=0x10 next cycle -> rvalid=1 exactly 2 edges after the read, rdata=0xDEADBEEF, rerr=0.
- Byte merge: write 0x11223344 to 0x20 (we=F), then byte store addr=0x22, we=4'b0100, data=0x00AA0000, then read 0x20 -> rdata=0x11AA3344.
- Back-to-back write then read of the same word in consecutive cycles, and read+write in the same request (old 0x1, new 0x2) -> consecutive read returns the new value; combined request returns 0x1; a later read returns 0x2.
- Out of range, DEPTH=16384: read addr=0x00010000 -> rvalid=1, rerr=1, rdata=0. Write there -> werr pulse, and no array alias at 0x0.
- clk_en held low 3 cycles with a read in A -> outputs frozen; rvalid appears on the 2nd enabled edge after issue.
- halt asserted while a write is in A -> word unchanged on a later read, rvalid=0. Async reset asserted mid-pipeline -> rvalid drops immediately, without waiting for a clock edge.
